// File: rtl/dmux_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmux_cnt_pkg
// Brief    : Shared constants, read-FSM state type and helpers for the
//            demux event counter bank.
// Revision : 1.0 - initial release
// ============================================================================
package dmux_cnt_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        ACK  = 2'd2
    } rd_state_e;

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [N_CH-1:0] v);
        return |(v & (v - N_CH'(1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmux_event_counter_if.sv
`default_nettype none
// ============================================================================
// Interface : dmux_event_counter_if
// Brief     : 4-phase read request/acknowledge port of the event counter bank.
// Revision  : 1.0 - initial release
// ============================================================================
interface dmux_event_counter_if
    import dmux_cnt_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             rd_req;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_clr;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output rd_req, rd_sel, rd_clr,
        input  rd_ack, rd_data
    );

    modport slave (
        input  rd_req, rd_sel, rd_clr,
        output rd_ack, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/dmux_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : dmux_sat_counter
// Brief    : One channel: saturating event counter with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load_one,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_ovf
);
    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;

    // i_load_one is the read-clear: restart at one if an event lands on the
    // same edge so it is not lost; the overflow flag is left untouched.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_load_one) begin
            r_cnt <= {{(WIDTH-1){1'b0}}, i_inc};
        end else if (i_inc) begin
            if (r_cnt != c_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= c_MAX - 1'b1) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/dmux_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : dmux_event_counter
// Brief    : Per-channel rising-edge counter bank behind the 1-to-8 demux,
//            with a 4-phase read/clear port and sticky ovf/err flags.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_event_counter
    import dmux_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     Y,
    input  logic                en,
    input  logic                clr,
    dmux_event_counter_if.slave rd_if,
    output logic [N_CH-1:0]     ovf,
    output logic                err
);
    localparam logic [1:0] c_ST_IDLE = 2'(IDLE);
    localparam logic [1:0] c_ST_CAP  = 2'(CAP);
    localparam logic [1:0] c_ST_ACK  = 2'(ACK);

    logic [N_CH-1:0]  r_y_q;
    logic [N_CH-1:0]  w_inc;
    logic [WIDTH-1:0] w_cnt [N_CH];
    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_clr_lat;
    logic             r_ack;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_cap;

    // Y_q resets to zero, so a strobe already high at reset release counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= Y;
        end
    end

    assign w_inc = en ? (Y & ~r_y_q) : '0;
    assign w_cap = (r_state == c_ST_CAP);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            dmux_sat_counter #(
                .WIDTH (WIDTH)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (clr),
                .i_load_one (w_cap && r_clr_lat && (r_sel == SEL_W'(i))),
                .i_inc      (w_inc[i]),
                .o_cnt      (w_cnt[i]),
                .o_ovf      (ovf[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_err <= 1'b0;
        end else if (multi_hot(Y)) begin
            r_err <= 1'b1;
        end
    end

    // Read FSM; clr deliberately has no effect here so an in-flight read
    // still returns the value captured before the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_sel     <= '0;
            r_clr_lat <= 1'b0;
            r_ack     <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rd_if.rd_req) begin
                        r_sel     <= rd_if.rd_sel;
                        r_clr_lat <= rd_if.rd_clr;
                        r_state   <= c_ST_CAP;
                    end
                end
                c_ST_CAP: begin
                    r_data  <= w_cnt[r_sel];
                    r_ack   <= 1'b1;
                    r_state <= c_ST_ACK;
                end
                c_ST_ACK: begin
                    if (!rd_if.rd_req) begin
                        r_ack   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rd_if.rd_ack  = r_ack;
    assign rd_if.rd_data = r_data;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmux_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_event_counter
// Brief    : Directed self-checking bench; WIDTH=8 and WIDTH=4 instances share
//            all stimulus so wide and saturating behaviour are seen together.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmux_event_counter;

    logic       clk;
    logic       rst;
    logic [7:0] Y;
    logic       en;
    logic       clr;
    logic       rd_req;
    logic [2:0] rd_sel;
    logic       rd_clr;
    logic [7:0] ovf8;
    logic [7:0] ovf4;
    logic       err8;
    logic       err4;

    int errors = 0;
    int checks = 0;

    dmux_event_counter_if #(.WIDTH(8)) if8 ();
    dmux_event_counter_if #(.WIDTH(4)) if4 ();

    assign if8.rd_req = rd_req;
    assign if8.rd_sel = rd_sel;
    assign if8.rd_clr = rd_clr;
    assign if4.rd_req = rd_req;
    assign if4.rd_sel = rd_sel;
    assign if4.rd_clr = rd_clr;

    dmux_event_counter #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .Y     (Y),
        .en    (en),
        .clr   (clr),
        .rd_if (if8),
        .ovf   (ovf8),
        .err   (err8)
    );

    dmux_event_counter #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .Y     (Y),
        .en    (en),
        .clr   (clr),
        .rd_if (if4),
        .ovf   (ovf4),
        .err   (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Stimulus helpers; all called and returning at a falling edge.
    task automatic pulse(input logic [7:0] y, input int n);
        for (int k = 0; k < n; k++) begin
            Y = y;
            @(negedge clk);
            Y = '0;
            @(negedge clk);
        end
    endtask

    task automatic clear_all();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] sel, input logic rc,
                           output logic [7:0] d8, output logic [3:0] d4,
                           output int ack_cyc, output logic ack_low);
        rd_sel  = sel;
        rd_clr  = rc;
        rd_req  = 1'b1;
        ack_cyc = 0;
        do begin
            @(negedge clk);
            ack_cyc++;
        end while (!if8.rd_ack && ack_cyc < 16);
        d8     = if8.rd_data;
        d4     = if4.rd_data;
        rd_req = 1'b0;
        rd_clr = 1'b0;
        @(negedge clk);
        ack_low = !if8.rd_ack && !if4.rd_ack;
    endtask

    task automatic test_reset();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        rst = 1'b1; en = 1'b1; Y = 8'h02;
        repeat (2) @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b0 || if4.rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b expected 0", if8.rd_ack, if4.rd_ack); end
        checks++; if (if8.rd_data !== 8'd0 || if4.rd_data !== 4'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d expected 0", if8.rd_data, if4.rd_data); end
        checks++; if (ovf8 !== 8'h00 || err8 !== 1'b0 || ovf4 !== 8'h00 || err4 !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf %h/%h err %b/%b expected 0", ovf8, ovf4, err8, err4); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        Y = '0;
        @(negedge clk);
        do_read(3'd1, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd1 || d4 !== 4'd1) begin errors++; $display("FAIL reset_release_edge: got %0d/%0d expected 1", d8, d4); end
    endtask

    task automatic test_reset_and_read();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        clear_all();
        pulse(8'h04, 3);
        do_read(3'd2, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd3 || d4 !== 4'd3) begin errors++; $display("FAIL read_ch2: got %0d/%0d expected 3", d8, d4); end
        checks++; if (ac !== 2) begin errors++; $display("FAIL read_latency: got %0d cycles expected 2", ac); end
        checks++; if (al !== 1'b1) begin errors++; $display("FAIL ack_release: got ack_low=%b expected 1", al); end
        do_read(3'd3, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd0 || d4 !== 4'd0) begin errors++; $display("FAIL read_ch3: got %0d/%0d expected 0", d8, d4); end
    endtask

    task automatic test_held_strobe();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        clear_all();
        Y = 8'h01;
        repeat (10) @(negedge clk);
        Y = '0;
        @(negedge clk);
        do_read(3'd0, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd1 || d4 !== 4'd1) begin errors++; $display("FAIL held_strobe: got %0d/%0d expected 1", d8, d4); end
        clear_all();
        en = 1'b0; Y = 8'h01;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (7) @(negedge clk);
        Y = '0;
        @(negedge clk);
        do_read(3'd0, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd0 || d4 !== 4'd0) begin errors++; $display("FAIL held_across_en: got %0d/%0d expected 0", d8, d4); end
    endtask

    task automatic test_saturation();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        clear_all();
        pulse(8'h80, 20);
        checks++; if (ovf4 !== 8'h80 || ovf8 !== 8'h00) begin errors++; $display("FAIL sat_ovf: got %h/%h expected 80/00", ovf4, ovf8); end
        do_read(3'd7, 1'b0, d8, d4, ac, al);
        checks++; if (d4 !== 4'd15 || d8 !== 8'd20) begin errors++; $display("FAIL sat_read: got w4=%0d w8=%0d expected 15/20", d4, d8); end
        clear_all();
        checks++; if (ovf4 !== 8'h00) begin errors++; $display("FAIL sat_clr_ovf: got %h expected 00", ovf4); end
        checks++; if (if4.rd_data !== 4'd15 || if8.rd_data !== 8'd20) begin errors++; $display("FAIL clr_keeps_data: got %0d/%0d expected 15/20", if4.rd_data, if8.rd_data); end
        do_read(3'd7, 1'b0, d8, d4, ac, al);
        checks++; if (d4 !== 4'd0 || d8 !== 8'd0) begin errors++; $display("FAIL sat_after_clr: got %0d/%0d expected 0", d4, d8); end
        pulse(8'h80, 16);
        do_read(3'd7, 1'b1, d8, d4, ac, al);
        checks++; if (d4 !== 4'd15 || d8 !== 8'd16) begin errors++; $display("FAIL sat_read_clr: got w4=%0d w8=%0d expected 15/16", d4, d8); end
        checks++; if (ovf4 !== 8'h80) begin errors++; $display("FAIL sat_ovf_sticky: got %h expected 80", ovf4); end
        do_read(3'd7, 1'b0, d8, d4, ac, al);
        checks++; if (d4 !== 4'd0 || d8 !== 8'd0) begin errors++; $display("FAIL sat_cleared: got %0d/%0d expected 0", d4, d8); end
    endtask

    task automatic test_read_clear_race();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        clear_all();
        pulse(8'h20, 6);
        rd_sel = 3'd5; rd_clr = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        Y = 8'h20;
        @(negedge clk);
        Y = '0;
        checks++; if (if8.rd_ack !== 1'b1 || if8.rd_data !== 8'd6 || if4.rd_data !== 4'd6) begin errors++; $display("FAIL race_capture: got ack=%b %0d/%0d expected 1 6/6", if8.rd_ack, if8.rd_data, if4.rd_data); end
        rd_req = 1'b0; rd_clr = 1'b0;
        @(negedge clk);
        do_read(3'd5, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd1 || d4 !== 4'd1) begin errors++; $display("FAIL race_second: got %0d/%0d expected 1", d8, d4); end
    endtask

    task automatic test_multi_hot();
        logic [7:0] d8; logic [3:0] d4; int ac; logic al;
        clear_all();
        checks++; if (err8 !== 1'b0 || err4 !== 1'b0) begin errors++; $display("FAIL mh_pre: got %b/%b expected 0", err8, err4); end
        pulse(8'h11, 1);
        checks++; if (err8 !== 1'b1 || err4 !== 1'b1) begin errors++; $display("FAIL mh_err: got %b/%b expected 1", err8, err4); end
        do_read(3'd0, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd1) begin errors++; $display("FAIL mh_ch0: got %0d expected 1", d8); end
        do_read(3'd4, 1'b0, d8, d4, ac, al);
        checks++; if (d8 !== 8'd1) begin errors++; $display("FAIL mh_ch4: got %0d expected 1", d8); end
        checks++; if (err8 !== 1'b1) begin errors++; $display("FAIL mh_sticky: got %b expected 1", err8); end
        clear_all();
        checks++; if (err8 !== 1'b0 || err4 !== 1'b0) begin errors++; $display("FAIL mh_clr: got %b/%b expected 0", err8, err4); end
    endtask

    task automatic test_reset_mid_read();
        clear_all();
        pulse(8'h0C, 1);
        rd_sel = 3'd3; rd_clr = 1'b0; rd_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b1 || if8.rd_data !== 8'd1) begin errors++; $display("FAIL mid_pre: got ack=%b data=%0d expected 1/1", if8.rd_ack, if8.rd_data); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b0 || if4.rd_ack !== 1'b0 || err8 !== 1'b0) begin errors++; $display("FAIL mid_rst: got ack=%b/%b err=%b expected 0", if8.rd_ack, if4.rd_ack, err8); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b0) begin errors++; $display("FAIL mid_cap: got ack=%b expected 0", if8.rd_ack); end
        @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b1 || if8.rd_data !== 8'd0 || if4.rd_data !== 4'd0) begin errors++; $display("FAIL mid_rerequest: got ack=%b %0d/%0d expected 1 0/0", if8.rd_ack, if8.rd_data, if4.rd_data); end
        rd_req = 1'b0;
        @(negedge clk);
        checks++; if (if8.rd_ack !== 1'b0) begin errors++; $display("FAIL mid_release: got ack=%b expected 0", if8.rd_ack); end
    endtask

    initial begin
        rst = 1'b1; Y = '0; en = 1'b1; clr = 1'b0;
        rd_req = 1'b0; rd_sel = '0; rd_clr = 1'b0;
        test_reset();
        test_reset_and_read();
        test_held_strobe();
        test_saturation();
        test_read_clear_race();
        test_multi_hot();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
